tl_d_channel_queue: RTL and testbench

TileLink-UL D-channel (response) buffer sitting directly upstream of the TL monitor tap on the core's memory port: it accepts responses from the slave side and presents them, decoupled by a ready/valid handshake, to the master side. The monitor observes its dequeue port. It is a circular-buffer FIFO with a count output and an optional same-cycle flow-through path.

---
 rtl/tl_d_channel_queue.sv | 139 +++++++++++++
 tb/tb_tl_d_channel_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_d_channel_queue.sv
// TileLink-UL D-channel response buffer.
// Circular-buffer FIFO between the slave side (enq_*) and the master side
// (deq_*), with an occupancy count. Any DEPTH from 1 to 16 is supported;
// pointers wrap by explicit compare so non-power-of-two depths work.
// Optional feature: define TL_DQUEUE_FLOW_EN to enable a zero-latency
// flow-through path when the buffer is empty.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high on that port. enq_ready depends only on stored state, never
// on enq_valid or deq_ready. Once deq_valid is high, the head entry stays
// stable until it is taken.
module tl_d_channel_queue #(
  parameter int DEPTH    = 2,
  parameter int SOURCE_W = 1,
  parameter int SIZE_W   = 2,
  parameter int DATA_W   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [2:0]                   enq_opcode,
  input  logic [1:0]                   enq_param,
  input  logic [SIZE_W-1:0]            enq_size,
  input  logic [SOURCE_W-1:0]          enq_source,
  input  logic                         enq_sink,
  input  logic                         enq_denied,
  input  logic                         enq_corrupt,
  input  logic [DATA_W-1:0]            enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [2:0]                   deq_opcode,
  output logic [1:0]                   deq_param,
  output logic [SIZE_W-1:0]            deq_size,
  output logic [SOURCE_W-1:0]          deq_source,
  output logic                         deq_sink,
  output logic                         deq_denied,
  output logic                         deq_corrupt,
  output logic [DATA_W-1:0]            deq_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 3 + 2 + SIZE_W + SOURCE_W + 1 + 1 + 1 + DATA_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               maybe_full_q, maybe_full_d;

  logic               ptr_match;
  logic               empty;
  logic               full;
  logic               do_enq;
  logic               do_deq;
  logic [ENTRY_W-1:0] enq_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic [PTR_W:0]     occ_diff;

  assign enq_entry = {enq_opcode, enq_param, enq_size, enq_source,
                      enq_sink, enq_denied, enq_corrupt, enq_data};
  assign head_entry = mem_q[rd_ptr_q];

  assign ptr_match = (wr_ptr_q == rd_ptr_q);
  assign empty     = ptr_match && !maybe_full_q;
  assign full      = ptr_match && maybe_full_q;

  // Full blocks the slave side even if a dequeue happens this cycle.
  assign enq_ready = !full;
  assign do_deq    = !empty && deq_ready;

`ifdef TL_DQUEUE_FLOW_EN
  // Empty buffer forwards the incoming response straight to the master side;
  // if it is taken immediately it is never stored.
  assign deq_valid = !empty || enq_valid;
  assign out_entry = empty ? enq_entry : head_entry;
  assign do_enq    = enq_valid && !full && !(empty && deq_ready);
`else
  assign deq_valid = !empty;
  assign out_entry = head_entry;
  assign do_enq    = enq_valid && !full;
`endif

  assign {deq_opcode, deq_param, deq_size, deq_source,
          deq_sink, deq_denied, deq_corrupt, deq_data} = out_entry;

  // Occupancy: pointer distance modulo DEPTH, with full overriding the
  // ambiguous equal-pointer case.
  always_comb begin
    occ_diff = '0;
    if (wr_ptr_q >= rd_ptr_q) begin
      occ_diff = {1'b0, wr_ptr_q} - {1'b0, rd_ptr_q};
    end else begin
      occ_diff = {1'b0, wr_ptr_q} + (PTR_W + 1)'(DEPTH) - {1'b0, rd_ptr_q};
    end
  end

  assign count = full ? CNT_W'(DEPTH) : CNT_W'(occ_diff);

  // Next-state for pointers and the full/empty disambiguation flag.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_deq) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // Control state; reset discards every buffered entry at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem_q[wr_ptr_q] <= enq_entry;
    end
  end

endmodule

// File: tb/tb_tl_d_channel_queue.sv
// Testbench for tl_d_channel_queue: a DEPTH=2 instance for directed
// fill/drain/full/flow/reset scenarios and a DEPTH=3 instance for randomized
// streams checked against a queue-based reference model.
module tb_tl_d_channel_queue;

`ifdef TL_DQUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic clock;
  logic reset;

  // DEPTH=2 instance signals; entries packed {op,param,size,src,sink,den,cor,data}
  logic        ev2, dr2;
  logic [42:0] e2;
  wire  [42:0] d2;
  wire         er2, dv2;
  wire  [1:0]  c2;

  // DEPTH=3 instance signals
  logic        ev3, dr3;
  logic [42:0] e3;
  wire  [42:0] d3;
  wire         er3, dv3;
  wire  [1:0]  c3;

  int checks = 0;
  int errors = 0;

  logic [42:0] exp_q[$];   // reference model contents of the DEPTH=3 buffer

  tl_d_channel_queue #(.DEPTH(2), .SOURCE_W(1), .SIZE_W(2), .DATA_W(32)) dut2 (
    .clock(clock), .reset(reset),
    .enq_valid(ev2), .enq_ready(er2),
    .enq_opcode(e2[42:40]), .enq_param(e2[39:38]), .enq_size(e2[37:36]),
    .enq_source(e2[35]), .enq_sink(e2[34]), .enq_denied(e2[33]),
    .enq_corrupt(e2[32]), .enq_data(e2[31:0]),
    .deq_valid(dv2), .deq_ready(dr2),
    .deq_opcode(d2[42:40]), .deq_param(d2[39:38]), .deq_size(d2[37:36]),
    .deq_source(d2[35]), .deq_sink(d2[34]), .deq_denied(d2[33]),
    .deq_corrupt(d2[32]), .deq_data(d2[31:0]),
    .count(c2)
  );

  tl_d_channel_queue #(.DEPTH(3), .SOURCE_W(1), .SIZE_W(2), .DATA_W(32)) dut3 (
    .clock(clock), .reset(reset),
    .enq_valid(ev3), .enq_ready(er3),
    .enq_opcode(e3[42:40]), .enq_param(e3[39:38]), .enq_size(e3[37:36]),
    .enq_source(e3[35]), .enq_sink(e3[34]), .enq_denied(e3[33]),
    .enq_corrupt(e3[32]), .enq_data(e3[31:0]),
    .deq_valid(dv3), .deq_ready(dr3),
    .deq_opcode(d3[42:40]), .deq_param(d3[39:38]), .deq_size(d3[37:36]),
    .deq_source(d3[35]), .deq_sink(d3[34]), .deq_denied(d3[33]),
    .deq_corrupt(d3[32]), .deq_data(d3[31:0]),
    .count(c3)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [42:0] rand_entry();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[42:0];
  endfunction

  // Load two entries into dut2 with deq_ready low.
  task automatic fill2(input logic [42:0] a, input logic [42:0] b);
    @(negedge clock); ev2 = 1'b1; e2 = a; dr2 = 1'b0;
    @(negedge clock); e2 = b;
    @(negedge clock); ev2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ev2 = 1'b1; e2 = rand_entry(); dr2 = 1'b1;
    ev3 = 1'b1; e3 = rand_entry(); dr3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      checks++; if (er2 !== 1'b1) begin errors++; $display("FAIL reset_enq_ready cyc%0d: got %b want 1", i, er2); end
      checks++; if (dv2 !== FLOW) begin errors++; $display("FAIL reset_deq_valid cyc%0d: got %b want %b", i, dv2, FLOW); end
      checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL reset_count cyc%0d: got %0d want 0", i, c2); end
      checks++; if (c3 !== 2'd0) begin errors++; $display("FAIL reset_count3 cyc%0d: got %0d want 0", i, c3); end
    end
    @(negedge clock);
    ev2 = 1'b0; dr2 = 1'b0; ev3 = 1'b0; dr3 = 1'b0;
    reset = 1'b1;
    @(negedge clock); #1;
    checks++; if (c2 !== 2'd0 || dv2 !== 1'b0) begin errors++; $display("FAIL reset_nowrite: got count %0d valid %b want 0 0", c2, dv2); end
    checks++; if (c3 !== 2'd0 || dv3 !== 1'b0) begin errors++; $display("FAIL reset_nowrite3: got count %0d valid %b want 0 0", c3, dv3); end
  endtask

  task automatic test_fill_drain();
    logic [42:0] a, b;
    a = rand_entry(); a[42:40] = 3'd1; a[31:0] = 32'hA5A5_0001;
    b = rand_entry(); b[42:40] = 3'd1; b[31:0] = 32'hA5A5_0002;
    @(negedge clock); ev2 = 1'b1; e2 = a; dr2 = 1'b0; #1;
    checks++; if (er2 !== 1'b1 || c2 !== 2'd0) begin errors++; $display("FAIL fill_first: got ready %b count %0d want 1 0", er2, c2); end
    @(negedge clock); e2 = b; #1;
    checks++; if (c2 !== 2'd1 || dv2 !== 1'b1) begin errors++; $display("FAIL fill_one: got count %0d valid %b want 1 1", c2, dv2); end
    checks++; if (d2 !== a) begin errors++; $display("FAIL fill_head: got %h want %h", d2, a); end
    @(negedge clock); ev2 = 1'b0; #1;
    checks++; if (c2 !== 2'd2 || er2 !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %b want 2 0", c2, er2); end
    @(negedge clock); dr2 = 1'b1; #1;
    checks++; if (d2 !== a || c2 !== 2'd2) begin errors++; $display("FAIL drain_first: got %h count %0d want %h 2", d2, c2, a); end
    @(negedge clock); #1;
    checks++; if (d2 !== b || c2 !== 2'd1 || dv2 !== 1'b1) begin errors++; $display("FAIL drain_second: got %h count %0d valid %b want %h 1 1", d2, c2, dv2, b); end
    @(negedge clock); dr2 = 1'b0; #1;
    checks++; if (c2 !== 2'd0 || dv2 !== 1'b0 || er2 !== 1'b1) begin errors++; $display("FAIL drain_empty: got count %0d valid %b ready %b want 0 0 1", c2, dv2, er2); end
  endtask

  task automatic test_full_simul();
    logic [42:0] a, b, x;
    a = rand_entry(); b = rand_entry(); x = rand_entry();
    fill2(a, b);
    ev2 = 1'b1; e2 = x; dr2 = 1'b1; #1;
    checks++; if (er2 !== 1'b0 || c2 !== 2'd2 || d2 !== a) begin errors++; $display("FAIL full_simul_same: got ready %b count %0d head %h want 0 2 %h", er2, c2, d2, a); end
    @(negedge clock); ev2 = 1'b0; dr2 = 1'b0; #1;
    checks++; if (c2 !== 2'd1 || er2 !== 1'b1) begin errors++; $display("FAIL full_simul_next: got count %0d ready %b want 1 1", c2, er2); end
    checks++; if (d2 !== b) begin errors++; $display("FAIL full_simul_head: got %h want %h", d2, b); end
    @(negedge clock); dr2 = 1'b1;
    @(negedge clock); dr2 = 1'b0; #1;
    checks++; if (c2 !== 2'd0 || dv2 !== 1'b0) begin errors++; $display("FAIL full_simul_drain: got count %0d valid %b want 0 0", c2, dv2); end
  endtask

  task automatic test_flow();
    logic [42:0] a;
    a = rand_entry(); a[31:0] = 32'h1234_5678;
    @(negedge clock); ev2 = 1'b1; e2 = a; dr2 = 1'b1; #1;
    checks++; if (dv2 !== FLOW || c2 !== 2'd0) begin errors++; $display("FAIL flow_same: got valid %b count %0d want %b 0", dv2, c2, FLOW); end
    checks++; if (dv2 === 1'b1 && d2 !== a) begin errors++; $display("FAIL flow_data: got %h want %h", d2, a); end
    @(negedge clock); ev2 = 1'b0; dr2 = 1'b0; #1;
    checks++; if (dv2 !== !FLOW || c2 !== (FLOW ? 2'd0 : 2'd1)) begin errors++; $display("FAIL flow_next: got valid %b count %0d want %b %0d", dv2, c2, !FLOW, FLOW ? 0 : 1); end
    checks++; if (dv2 === 1'b1 && d2 !== a) begin errors++; $display("FAIL flow_next_data: got %h want %h", d2, a); end
    @(negedge clock); dr2 = 1'b1;
    @(negedge clock); dr2 = 1'b0; #1;
    checks++; if (c2 !== 2'd0 || dv2 !== 1'b0) begin errors++; $display("FAIL flow_drain: got count %0d valid %b want 0 0", c2, dv2); end
  endtask

  task automatic test_reset_mid();
    fill2(rand_entry(), rand_entry());
    #1;
    checks++; if (c2 !== 2'd2) begin errors++; $display("FAIL reset_mid_pre: got count %0d want 2", c2); end
    #2; reset = 1'b0; #1;
    checks++; if (dv2 !== 1'b0 || c2 !== 2'd0 || er2 !== 1'b1) begin errors++; $display("FAIL reset_mid_async: got valid %b count %0d ready %b want 0 0 1", dv2, c2, er2); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1;
    checks++; if (dv2 !== 1'b0 || c2 !== 2'd0) begin errors++; $display("FAIL reset_mid_after: got valid %b count %0d want 0 0", dv2, c2); end
  endtask

  // Random stream through the DEPTH=3 instance against a queue model.
  task automatic test_stream(input int n, input bit alt_src);
    logic [42:0] pend[$];
    logic [42:0] ent, exp_head;
    logic exp_valid, exp_ready, acc, pop, byp;
    int cyc, got;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ent = rand_entry();
      if (alt_src) ent[35] = i[0];
      pend.push_back(ent);
    end
    cyc = 0; got = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && cyc < 500) begin
      @(negedge clock);
      ev3 = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
      e3  = (pend.size() > 0) ? pend[0] : rand_entry();
      dr3 = 1'($urandom_range(0, 1));
      #1;
      exp_valid = (exp_q.size() > 0) || (FLOW && ev3);
      exp_head  = (exp_q.size() > 0) ? exp_q[0] : e3;
      exp_ready = (exp_q.size() < 3);
      checks++; if (er3 !== exp_ready) begin errors++; $display("FAIL stream_ready cyc%0d: got %b want %b", cyc, er3, exp_ready); end
      checks++; if (dv3 !== exp_valid) begin errors++; $display("FAIL stream_valid cyc%0d: got %b want %b", cyc, dv3, exp_valid); end
      checks++; if (c3 !== 2'(exp_q.size())) begin errors++; $display("FAIL stream_count cyc%0d: got %0d want %0d", cyc, c3, exp_q.size()); end
      if (exp_valid && dr3) begin
        got++;
        checks++; if (d3 !== exp_head) begin errors++; $display("FAIL stream_data cyc%0d: got %h want %h", cyc, d3, exp_head); end
      end
      acc = ev3 && exp_ready;
      pop = dr3 && (exp_q.size() > 0);
      byp = FLOW && ev3 && dr3 && (exp_q.size() == 0);
      if (pop) void'(exp_q.pop_front());
      if (acc && !byp) exp_q.push_back(e3);
      if (acc) void'(pend.pop_front());
      cyc++;
    end
    @(negedge clock); ev3 = 1'b0; dr3 = 1'b0; #1;
    checks++; if (cyc >= 500) begin errors++; $display("FAIL stream_timeout: got %0d cycles want < 500", cyc); end
    checks++; if (got !== n) begin errors++; $display("FAIL stream_total: got %0d responses want %0d", got, n); end
    checks++; if (c3 !== 2'd0 || dv3 !== 1'b0) begin errors++; $display("FAIL stream_end: got count %0d valid %b want 0 0", c3, dv3); end
  endtask

  initial begin
    reset = 1'b0;
    ev2 = 1'b0; dr2 = 1'b0; e2 = '0;
    ev3 = 1'b0; dr3 = 1'b0; e3 = '0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_flow();
    test_reset_mid();
    test_stream(10, 1'b1);
    test_stream(60, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
